// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the byte-wide memory bank between the UART boot
// loader (ld_*) and the CPU control FSM (cpu_*). Each granted 32-bit word
// request is sequenced as four big-endian byte accesses (addr+0 = [31:24]),
// followed by a drain cycle for the last synchronous read byte and a single
// ack cycle. Request-to-ack latency is 6 cycles for reads and writes alike.
//
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, simultaneous
// requests alternate (grant goes to the requester that is not `owner`);
// when undefined, the loader has fixed priority over the CPU.
module mem_port_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_50,
    input  logic              rst_board_n,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       rdata,
    output logic              owner,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Word-aligned address mask; low two bits of requester addresses are ignored.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            state_q, state_d;
    logic [1:0]        cnt_q;
    logic              owner_q;
    logic [31:0]       rdata_q;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [23:0]       asm_q;
    logic              any_req;
    logic              grant_ld;
    logic              start;

    // Big-endian byte lane k of a word: k=0 is the most significant byte.
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign any_req = ld_req | cpu_req;
    assign start   = (state_q == IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
    // On contention the previous owner yields; a lone request always wins.
    assign grant_ld = ld_req & (~cpu_req | ~owner_q);
`else
    // Fixed priority: the loader always wins when it asks.
    assign grant_ld = ld_req;
`endif

    // FSM state register.
    always_ff @(posedge clk_50 or negedge rst_board_n) begin
        if (!rst_board_n) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Next-state logic and memory/ack strobes decoded from the current state.
    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        ld_ack    = 1'b0;
        cpu_ack   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = XFER;
            end
            XFER: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                // base is aligned, so OR-ing the lane index never carries out.
                mem_addr  = base_q | {{(ADDR_W-2){1'b0}}, cnt_q};
                mem_wdata = be_byte(wdata_q, cnt_q);
                if (cnt_q == 2'd3) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = ACK;
            end
            ACK: begin
                ld_ack  = owner_q;
                cpu_ack = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant owner, byte counter and the returned read word.
    always_ff @(posedge clk_50 or negedge rst_board_n) begin
        if (!rst_board_n) begin
            cnt_q   <= 2'd0;
            owner_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            if (start) begin
                owner_q <= grant_ld;
                cnt_q   <= 2'd0;
            end else if (state_q == XFER) begin
                cnt_q <= cnt_q + 2'd1;
            end
            // Last byte arrives during DRAIN; publish the full word for the ack cycle.
            if ((state_q == DRAIN) && !we_q) rdata_q <= {asm_q, mem_rdata};
        end
    end

    // Transaction capture at grant and read-byte assembly (data only, no reset).
    always_ff @(posedge clk_50) begin
        if (start) begin
            we_q    <= grant_ld ? ld_we : cpu_we;
            base_q  <= (grant_ld ? ld_addr : cpu_addr) & ALIGN_MASK;
            wdata_q <= grant_ld ? ld_wdata : cpu_wdata;
        end
        // Bytes 0..2 return one cycle after their strobe, i.e. while k = 1..3.
        if ((state_q == XFER) && (cnt_q != 2'd0) && !we_q)
            asm_q <= {asm_q[15:0], mem_rdata};
    end

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, contention,
// back-to-back, mid-transaction reset and random transactions checked
// against a word-level memory model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;

    logic              clk_50;
    logic              rst_board_n;
    logic              ld_req, ld_we, ld_ack;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_wdata;
    logic              cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       rdata;
    logic              owner, busy;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_50(clk_50), .rst_board_n(rst_board_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .rdata(rdata), .owner(owner), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk_50 = 1'b0;
        forever #10 clk_50 = ~clk_50;
    end

    // Byte-wide synchronous memory bank plus an access log.
    logic [7:0]  mem [0:65535];
    int          cyc;
    logic [15:0] log_addr[$];
    logic [7:0]  log_data[$];
    logic        log_we[$];
    int          log_cyc[$];

    always @(posedge clk_50) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_we.push_back(mem_we);
            log_cyc.push_back(cyc);
        end
    end

    // Reference model: word-level view of memory contents and arbiter state.
    logic [7:0]  ref_mem [int];
    logic [31:0] m_rdata;
    bit          m_owner;
    logic [15:0] bases[$];

    int n_pass, n_total;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_word(input logic [15:0] b);
        return {ref_mem[int'(b)], ref_mem[int'(b) + 1], ref_mem[int'(b) + 2], ref_mem[int'(b) + 3]};
    endfunction

    task automatic ref_write(input logic [15:0] b, input logic [31:0] w);
        for (int k = 0; k < 4; k++) ref_mem[int'(b) + k] = 8'((w >> (24 - 8 * k)) & 32'hFF);
        bases.push_back(b);
    endtask

    // One requester, one word; starts and ends on a falling edge with the DUT idle.
    task automatic run_txn(input string tag, input bit is_ld, input bit we,
                           input logic [15:0] addr, input logic [31:0] wd,
                           output logic [31:0] got_rd);
        logic [15:0] base;
        logic [31:0] exp_rd;
        int          lat;
        bit          other_ack, got_owner, ack_after;
        base   = addr & 16'hFFFC;
        exp_rd = we ? m_rdata : ref_word(base);
        log_addr.delete(); log_data.delete(); log_we.delete(); log_cyc.delete();
        if (is_ld) begin ld_req = 1; ld_we = we; ld_addr = addr; ld_wdata = wd; end
        else       begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
        @(posedge clk_50);
        #1;
        // Everything but req is don't-care once granted.
        if (is_ld) begin ld_we = 1'($urandom); ld_addr = 16'($urandom); ld_wdata = $urandom; end
        else       begin cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = $urandom; end
        lat = -1; other_ack = 0; got_owner = 0; got_rd = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_50);
            if (is_ld ? cpu_ack : ld_ack) other_ack = 1;
            if (is_ld ? ld_ack : cpu_ack) begin
                lat = i; got_rd = rdata; got_owner = owner;
                break;
            end
        end
        ld_req = 0; cpu_req = 0;
        @(negedge clk_50);
        ack_after = ld_ack | cpu_ack;
        check({tag, " latency"}, lat, 6);
        check({tag, " rdata"}, got_rd, exp_rd);
        check({tag, " owner"}, got_owner, is_ld);
        check({tag, " other ack"}, other_ack, 0);
        check({tag, " ack pulse width"}, ack_after, 0);
        check({tag, " access count"}, log_addr.size(), 4);
        for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
            check($sformatf("%s addr[%0d]", tag, k), log_addr[k], 16'(base + 16'(k)));
            check($sformatf("%s we[%0d]", tag, k), log_we[k], we);
            if (we) check($sformatf("%s wbyte[%0d]", tag, k), log_data[k], (wd >> (24 - 8 * k)) & 32'hFF);
            if (k > 0) check($sformatf("%s spacing[%0d]", tag, k), log_cyc[k] - log_cyc[k-1], 1);
        end
        if (we) ref_write(base, wd);
        else    m_rdata = exp_rd;
        m_owner = is_ld;
    endtask

    typedef struct {
        bit          is_ld;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] rd;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        bit          exp_ld_first, both, ack_seen;
        int          ld_t, cpu_t, low_cnt;
        int          ack_t[$];
        logic [31:0] cpu_rd;
        logic [31:0] b2b_rd[$];

        n_pass = 0; n_total = 0;
        m_rdata = 32'h0; m_owner = 0;
        rst_board_n = 0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;

        // Reset state.
        #15;
        check("reset outputs", {ld_ack, cpu_ack, rdata, owner, busy, mem_en, mem_we, mem_addr, mem_wdata}, 0);
        @(negedge clk_50); rst_board_n = 1;
        @(negedge clk_50);
        check("idle after reset busy", busy, 0);

        // Directed vectors: {loader?, write?, addr, wdata, rdata after ack}.
        vecs[0] = '{1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b1, 1'b1, 16'h0020, 32'h12345678, 32'h00000000};
        vecs[2] = '{1'b0, 1'b0, 16'h0023, 32'h00000000, 32'h12345678};
        vecs[3] = '{1'b0, 1'b1, 16'hFFFC, 32'hA1B2C3D4, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFE, 32'h00000000, 32'hA1B2C3D4};
        vecs[5] = '{1'b0, 1'b0, 16'h0011, 32'h00000000, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 1'b1, 16'h0040, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[7] = '{1'b1, 1'b1, 16'h0103, 32'hCAFEF00D, 32'hDEADBEEF};
        for (int v = 0; v < 8; v++) begin
            run_txn($sformatf("vec%0d", v), vecs[v].is_ld, vecs[v].we, vecs[v].addr, vecs[v].wdata, rd);
            check($sformatf("vec%0d table rdata", v), rd, vecs[v].exp_rdata);
        end

        // Contention: both requests rise together.
`ifdef ARB_ROUND_ROBIN_EN
        exp_ld_first = (m_owner == 0);
`else
        exp_ld_first = 1;
`endif
        ld_req = 1; ld_we = 1; ld_addr = 16'h0200; ld_wdata = 32'h0BADCAFE;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; cpu_wdata = 32'h0;
        ld_t = -1; cpu_t = -1; both = 0; cpu_rd = 32'h0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_50);
            if (ld_ack && cpu_ack) both = 1;
            if (ld_ack && ld_t < 0) begin ld_t = i; ld_req = 0; end
            if (cpu_ack && cpu_t < 0) begin cpu_t = i; cpu_rd = rdata; cpu_req = 0; end
            if (ld_t >= 0 && cpu_t >= 0) break;
        end
        ld_req = 0; cpu_req = 0;
        check("contention first ack", exp_ld_first ? ld_t : cpu_t, 6);
        check("contention second ack", exp_ld_first ? cpu_t : ld_t, 13);
        check("contention dual ack", both, 0);
        check("contention cpu rdata", cpu_rd, ref_word(16'h0010));
        ref_write(16'h0200, 32'h0BADCAFE);
        m_rdata = ref_word(16'h0010);
        m_owner = exp_ld_first ? 1'b0 : 1'b1;
        @(negedge clk_50);

        // Back-to-back: CPU holds req across three reads.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        low_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_50);
            if (cpu_ack) begin
                ack_t.push_back(i);
                b2b_rd.push_back(rdata);
                if (ack_t.size() == 3) begin cpu_req = 0; break; end
            end else if (ack_t.size() > 0 && !busy) begin
                low_cnt++;
            end
        end
        cpu_req = 0;
        check("b2b ack count", ack_t.size(), 3);
        for (int k = 0; k < 3 && k < ack_t.size(); k++) begin
            check($sformatf("b2b ack time[%0d]", k), ack_t[k], 6 + 7 * k);
            check($sformatf("b2b rdata[%0d]", k), b2b_rd[k], 32'h12345678);
        end
        check("b2b busy low cycles", low_cnt, 2);
        m_rdata = 32'h12345678; m_owner = 0;
        @(negedge clk_50);

        // Reset mid-write after two bytes have landed.
        ld_req = 1; ld_we = 1; ld_addr = 16'h0040; ld_wdata = 32'h11223344;
        @(posedge clk_50);
        @(posedge clk_50);
        @(posedge clk_50);
        #5 rst_board_n = 0;
        #1;
        check("abort outputs", {ld_ack, cpu_ack, rdata, owner, busy, mem_en, mem_we, mem_addr, mem_wdata}, 0);
        ack_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50);
            ld_req = 0;
            ack_seen = ack_seen | ld_ack | cpu_ack;
        end
        rst_board_n = 1;
        @(negedge clk_50);
        ack_seen = ack_seen | ld_ack | cpu_ack;
        check("abort no ack", ack_seen, 0);
        check("abort idle busy", busy, 0);
        ref_mem[16'h0040] = 8'h11; ref_mem[16'h0041] = 8'h22;
        m_rdata = 32'h0; m_owner = 0;
        run_txn("abort readback", 1'b0, 1'b0, 16'h0041, 32'h0, rd);
        check("abort partial word", rd, 32'h1122A5A5);

        // Random single-requester traffic against the model.
        for (int n = 0; n < 40; n++) begin
            bit          r_ld, r_we;
            logic [15:0] r_addr;
            int          gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) @(negedge clk_50);
            r_ld = 1'($urandom_range(0, 1));
            r_we = (bases.size() == 0) || ($urandom_range(0, 1) == 1);
            if (r_we) r_addr = ($urandom_range(0, 7) == 0) ? (16'hFFFC | 16'($urandom_range(0, 3)))
                                                           : 16'($urandom_range(0, 255));
            else      r_addr = bases[$urandom_range(0, bases.size() - 1)] | 16'($urandom_range(0, 3));
            run_txn($sformatf("rnd%0d", n), r_ld, r_we, r_addr, $urandom, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide memory bank, which holds the instruction and data image, between two requesters: the UART boot loader (ld_*) and the CPU control FSM (cpu_*).
- Each requester issues 32-bit word transactions. The arbiter grants one requester at a time and sequences each word as four big-endian byte accesses: byte at addr+0 is bits [31:24].
- Word data is assembled and returned to the requester with a single-cycle ack pulse.
- Sits between the control module and the memory bank, replacing direct memory_bank access.

Parameters:
- ADDR_W, 16: byte address width of both requester ports and the memory port.

Ports:
- clk_50  in  1  system clock, 50 MHz
- rst_board_n  in  1  asynchronous, active-low reset
- ld_req  in  1  loader request; held high until ld_ack
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  ADDR_W  loader byte address; bits [1:0] ignored
- ld_wdata  in  32  loader write word
- ld_ack  out  1  one-cycle completion pulse to loader
- cpu_req  in  1  CPU request; held high until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU byte address; bits [1:0] ignored
- cpu_wdata  in  32  CPU write word
- cpu_ack  out  1  one-cycle completion pulse to CPU
- rdata  out  32  read word; valid in the ack cycle, held until the next read completes
- owner  out  1  current/last grant: 0 = CPU, 1 = loader
- busy  out  1  high while a transaction is in flight
- mem_en  out  1  memory byte access strobe
- mem_we  out  1  memory byte write enable
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  8  memory byte write data
- mem_rdata  in  8  memory read byte; valid the cycle after mem_en with mem_we=0 (synchronous read)

Behaviour:
- Reset is asynchronous on the falling edge of rst_board_n. All outputs go to 0: ld_ack, cpu_ack, rdata, owner, busy, mem_en, mem_we, mem_addr, mem_wdata. FSM goes to IDLE, byte counter to 0.
- Reset asserted mid-transaction aborts it: no ack is issued, and partial writes already done remain in memory.
- FSM has four states: IDLE, XFER, DRAIN, ACK.
- IDLE:
  - If any request is high, select a winner (see arbitration).
  - Latch the winner's we, {addr[ADDR_W-1:2],2'b00} and wdata.
  - Set owner, set busy=1, counter=0, go to XFER.
- XFER, 4 cycles, counter k = 0..3:
  - mem_en=1, mem_addr=base+k, mem_we=latched we.
  - mem_wdata = wdata byte k, big-endian (k=0 gives [31:24]).
  - For reads, the byte returned in the following cycle is shifted into the rdata assembly register.
  - At k=3 go to DRAIN.
- DRAIN, 1 cycle:
  - mem_en=0.
  - For reads, capture the final byte (address base+3) into [7:0].
  - Go to ACK.
- ACK, 1 cycle:
  - Pulse the winner's ack. If read, rdata is updated with the assembled word.
  - busy=0, go to IDLE.
- Latency is uniform for reads and writes: request sampled in IDLE at cycle T gives ack at T+6. The next grant can be sampled at T+7.
- Writes never modify rdata.
- Requester inputs other than req are don't-care after the grant, because they are latched.
- Requests are sampled only in IDLE. A req that drops before grant is simply never served.
- A req still high in the cycle after its own ack is treated as a new request.
- Arbitration (default): fixed priority, loader over CPU. Simultaneous requests in IDLE grant the loader.
- Address wrap: base+k is computed modulo 2^ADDR_W. The final word at the top of memory stays within it because base is aligned.
- Non-granted ack stays 0. Both acks are never high in the same cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On simultaneous requests, grant the requester that is not `owner`, i.e. alternate. A lone request is always granted.
- Undefined: fixed priority, loader over CPU, as above. CPU can starve while the loader streams.

Test Plan:
- Reset: drive rst_board_n low asynchronously, mid-cycle, during a write. All outputs read 0 immediately, no ack appears, and FSM returns to IDLE once rst_board_n is deasserted.
- Loader write: ld_we=1, ld_addr=0x0010, ld_wdata=0xDEADBEEF. Expect mem writes 0xDE@0x10, 0xAD@0x11, 0xBE@0x12, 0xEF@0x13 on consecutive cycles, with ld_ack exactly 6 cycles after the request is sampled.
- CPU read: preload bytes 0x12,0x34,0x56,0x78 at 0x0020, then cpu_addr=0x0023 (low bits ignored). Expect mem_addr 0x20..0x23, cpu_ack at T+6, rdata=0x12345678.
- Contention: ld_req and cpu_req both rise in the same cycle. Without the macro, the loader is served first, then the CPU, and acks are 7 cycles apart. With ARB_ROUND_ROBIN_EN and owner=1 at start, the CPU is served first.
- Wrap: ADDR_W=16, write 0xA1B2C3D4 at 0xFFFC. Expect bytes at 0xFFFC..0xFFFF and no access to 0x0000.
- Back-to-back: CPU holds cpu_req for 3 reads with the loader idle. Acks land at T+6, T+13, T+20, and busy drops for exactly one cycle between transactions.
